// File: rtl/memc_deskew.sv
// Realigns the skewed result stream leaving the systolic array so that each
// result row appears on all lanes in one cycle, framed with valid/index/done.
module memc_deskew #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    en,
  input  logic [DIM*BITS_C-1:0]   Cin,
  output logic [DIM*BITS_C-1:0]   Cout,
  output logic                    row_valid,
  output logic [$clog2(DIM)-1:0]  row_idx,
  output logic                    done
);

  localparam int IW = $clog2(DIM);
  localparam int CW = $clog2(2*DIM+1);
  localparam logic [CW-1:0] FIRST = CW'(DIM-1);
  localparam logic [CW-1:0] LAST  = CW'(2*DIM-2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic             adv;
  logic [DIM*BITS_C-1:0] tap;

  // start always wins over en, so the Cin sampled with start never enters a line
  assign adv = (state_q == RUN) && en && !start;

  // Stage p0: per-lane shift lines, lane j delayed DIM-1-j en-cycles
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    logic signed [BITS_C-1:0] din;
    assign din = Cin[j*BITS_C +: BITS_C];
    if (j == DIM-1) begin : g_direct
      assign tap[j*BITS_C +: BITS_C] = din;
    end else begin : g_line
      logic signed [BITS_C-1:0] line_p0 [DIM-1-j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DIM-1-j; i++) line_p0[i] <= '0;
        end else if (start) begin
          for (int i = 0; i < DIM-1-j; i++) line_p0[i] <= '0;
        end else if (adv) begin
          line_p0[0] <= din;
          for (int i = 1; i < DIM-1-j; i++) line_p0[i] <= line_p0[i-1];
        end
      end
      assign tap[j*BITS_C +: BITS_C] = line_p0[DIM-2-j];
    end
  end

  // Stage p1: common aligned output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     Cout <= '0;
    else if (start) Cout <= '0;
    else if (adv)   Cout <= tap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = RUN;
    else if (adv && cnt == LAST)
      state_d = DONE;
  end

  // Row framing follows the en-cycle count; rows emerge for counts FIRST..LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      if (adv) begin
        cnt <= cnt + CW'(1);
        if (cnt >= FIRST) begin
          row_valid <= 1'b1;
          row_idx   <= IW'(cnt - FIRST);
        end
        if (cnt == LAST) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memc_deskew.sv
// Directed bench for memc_deskew: a DIM=4/16-bit instance for framing, stalls,
// aborts and reset, plus a DIM=8/24-bit instance with random data.
module tb_memc_deskew;

  localparam int D  = 4;
  localparam int W  = 16;
  localparam int D8 = 8;
  localparam int W8 = 24;

  logic clk = 1'b0;
  logic rst_n;
  logic start, en;
  logic [D*W-1:0] cin;
  logic [D*W-1:0] cout;
  logic rv;
  logic [1:0] ridx;
  logic dn;

  logic start8, en8;
  logic [D8*W8-1:0] cin8;
  logic [D8*W8-1:0] cout8;
  logic rv8;
  logic [2:0] ridx8;
  logic dn8;

  int n_chk = 0;
  int n_pass = 0;

  logic [W8-1:0] mat [D8][D8];

  always #5 clk = ~clk;

  memc_deskew #(.BITS_C(W), .DIM(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .Cin(cin),
    .Cout(cout), .row_valid(rv), .row_idx(ridx), .done(dn)
  );

  memc_deskew #(.BITS_C(W8), .DIM(D8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .en(en8), .Cin(cin8),
    .Cout(cout8), .row_valid(rv8), .row_idx(ridx8), .done(dn8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] elem(input int pat, input int r, input int j);
    if (pat == 0) return W'(16*r + j);
    return W'(-(r+1)*(j+1));
  endfunction

  task automatic drive_cin(input int pat, input int k);
    for (int j = 0; j < D; j++) begin
      int r;
      r = k - j;
      cin[j*W +: W] = (r >= 0 && r < D) ? elem(pat, r, j) : '0;
    end
  endtask

  // Starts a tile (with en=1 and junk Cin on the start cycle) and feeds up to
  // 'limit' en-cycles, checking framing and data after every edge.
  task automatic run_tile(input int pat, input int toggle, input int limit);
    int k, cyc;
    logic e;
    start = 1'b1; en = 1'b1; cin = {D{16'h7777}};
    tick();
    start = 1'b0;
    chk("start_rv", rv, 0);
    chk("start_done", dn, 0);
    chk("start_cout", cout, 0);
    k = 0; cyc = 0;
    while (k < 2*D-1 && k < limit && cyc < 100) begin
      e = toggle ? (cyc % 2 == 0) : 1'b1;
      en = e;
      if (e) drive_cin(pat, k);
      else cin = {$urandom, $urandom};
      tick();
      cyc++;
      if (e) begin
        chk("rv", rv, (k >= D-1));
        if (k >= D-1) begin
          chk("row_idx", ridx, k-(D-1));
          for (int j = 0; j < D; j++) chk("cout", cout[j*W +: W], elem(pat, k-(D-1), j));
        end
        chk("done", dn, (k == 2*D-2));
        k++;
      end else begin
        chk("stall_rv", rv, 0);
        chk("stall_done", dn, 0);
      end
    end
    if (cyc >= 100) chk("timeout", 0, 1);
    if (limit >= 2*D-1) begin
      for (int c = 0; c < 3; c++) begin
        en = 1'b1; cin = {$urandom, $urandom};
        tick();
        chk("post_rv", rv, 0);
        chk("post_done", dn, 1);
        for (int j = 0; j < D; j++) chk("post_cout", cout[j*W +: W], elem(pat, D-1, j));
      end
    end
    en = 1'b0;
  endtask

  initial begin
    int k, cyc, rows;
    rst_n = 1'b0; start = 1'b0; en = 1'b0; cin = '0;
    start8 = 1'b0; en8 = 1'b0; cin8 = '0;
    #12;
    chk("rst_cout", cout, 0);
    chk("rst_rv", rv, 0);
    chk("rst_idx", ridx, 0);
    chk("rst_done", dn, 0);
    chk("rst_done8", dn8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // en ignored while IDLE
    en = 1'b1; cin = {D{16'h1234}};
    tick(); tick();
    chk("idle_rv", rv, 0);
    chk("idle_cout", cout, 0);
    en = 1'b0;

    run_tile(0, 0, 99);   // continuous en
    run_tile(0, 1, 99);   // en toggling
    run_tile(1, 0, 99);   // negative data
    run_tile(0, 0, 5);    // aborted tile
    run_tile(0, 0, 99);   // fresh tile after abort

    // asynchronous reset mid-run
    run_tile(1, 0, 5);
    rst_n = 1'b0;
    #1;
    chk("mrst_cout", cout, 0);
    chk("mrst_rv", rv, 0);
    chk("mrst_done", dn, 0);
    chk("mrst_idx", ridx, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      en = 1'b1; cin = {$urandom, $urandom};
      tick();
      chk("after_rst_rv", rv, 0);
      chk("after_rst_done", dn, 0);
    end
    en = 1'b0;
    run_tile(1, 0, 99);

    // DIM=8 random tile with random stalls
    for (int r = 0; r < D8; r++)
      for (int j = 0; j < D8; j++) mat[r][j] = W8'($urandom);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    k = 0; cyc = 0; rows = 0;
    while (k < 2*D8-1 && cyc < 200) begin
      en8 = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < D8; j++) begin
        int r;
        r = k - j;
        cin8[j*W8 +: W8] = (r >= 0 && r < D8) ? mat[r][j] : W8'($urandom);
      end
      if (en8) k++;
      tick();
      cyc++;
      if (rv8) begin
        chk("b_idx", ridx8, rows);
        for (int j = 0; j < D8; j++) chk("b_cout", cout8[j*W8 +: W8], mat[rows % D8][j]);
        rows++;
      end
    end
    if (cyc >= 200) chk("b_timeout", 0, 1);
    for (int c = 0; c < 20; c++) begin
      en8 = 1'b1; cin8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      if (rv8) rows++;
      chk("b_sticky_done", dn8, 1);
    end
    en8 = 1'b0;
    chk("b_pulses", rows, D8);
    for (int j = 0; j < D8; j++) chk("b_hold", cout8[j*W8 +: W8], mat[D8-1][j]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
